// File: rtl/tone_cfg_pkg.sv
// Shared types and constants for the tone configuration commit controller.
// Entries are addressed as {ch, tone}: A0..A7 occupy 0..7 and B0..B7 occupy 8..15.
package tone_cfg_pkg;

    localparam int unsigned DEF_IDX_W  = 10;
    localparam int unsigned DEF_GAIN_W = 18;
    localparam int unsigned N_ENTRY    = 16;
    localparam int unsigned ADDR_W     = $clog2(N_ENTRY);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StCopy    = 2'd2,
        StDone    = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] entry_addr(input logic ch, input logic [2:0] tone);
        return {ch, tone};
    endfunction

endpackage

// File: rtl/tone_shadow_bank.sv
// 16-entry shadow register file holding {index, gain} per tone.
// It has one synchronous write port with split field enables and one combinational read port.
module tone_shadow_bank
    import tone_cfg_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned GAIN_W = DEF_GAIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idx_we,
    input  logic              gain_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [GAIN_W-1:0] wr_gain,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [IDX_W-1:0]  rd_index,
    output logic [GAIN_W-1:0] rd_gain
);

    logic [IDX_W-1:0]  index_q [N_ENTRY];
    logic [GAIN_W-1:0] gain_q  [N_ENTRY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_ENTRY); i++) begin
                index_q[i] <= '0;
                gain_q[i]  <= '0;
            end
        end else begin
            if (idx_we) begin
                index_q[wr_addr] <= wr_index;
            end
            if (gain_we) begin
                gain_q[wr_addr] <= wr_gain;
            end
        end
    end

    // A read in the write cycle returns the old contents.
    assign rd_index = index_q[rd_addr];
    assign rd_gain  = gain_q[rd_addr];

endmodule

// File: rtl/tone_cfg_commit_ctrl.sv
// Double-buffered tone configuration controller: collects shadow writes, then on a
// SAFE-gated commit copies all 16 entries to the active table at the next frame boundary.
module tone_cfg_commit_ctrl
    import tone_cfg_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned GAIN_W = DEF_GAIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idx_we,
    input  logic              gain_we,
    input  logic              wr_ch,
    input  logic [2:0]        wr_tone,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [GAIN_W-1:0] wr_gain,
    input  logic              commit_req,
    input  logic              safe_we,
    input  logic              safe_val,
    input  logic              frame_sync,
    output logic              act_we,
    output logic              act_ch,
    output logic [2:0]        act_tone,
    output logic [IDX_W-1:0]  act_index,
    output logic [GAIN_W-1:0] act_gain,
    output logic              busy,
    output logic              dirty,
    output logic              safe_state,
    output logic              commit_done,
    output logic              commit_rej
);

    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(N_ENTRY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rearm_q, rearm_d;
    logic              safe_q, safe_d;
    logic              dirty_q, dirty_d;

    logic              start_copy;
    logic              reject;
    logic              abort;
    logic              shadow_wr;

    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  rd_index;
    logic [GAIN_W-1:0] rd_gain;

    logic              act_we_d, act_ch_d;
    logic [2:0]        act_tone_d;
    logic [IDX_W-1:0]  act_index_d;
    logic [GAIN_W-1:0] act_gain_d;
    logic              busy_d, done_d, rej_d;

    logic              act_we_q, act_ch_q;
    logic [2:0]        act_tone_q;
    logic [IDX_W-1:0]  act_index_q;
    logic [GAIN_W-1:0] act_gain_q;
    logic              busy_q, done_q, rej_q;

    tone_shadow_bank #(
        .IDX_W  (IDX_W),
        .GAIN_W (GAIN_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .idx_we   (idx_we),
        .gain_we  (gain_we),
        .wr_addr  (entry_addr(wr_ch, wr_tone)),
        .wr_index (wr_index),
        .wr_gain  (wr_gain),
        .rd_addr  (rd_addr),
        .rd_index (rd_index),
        .rd_gain  (rd_gain)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rearm_q <= 1'b0;
            safe_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rearm_q <= rearm_d;
            safe_q  <= safe_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rearm_d    = rearm_q;
        start_copy = 1'b0;
        reject     = 1'b0;
        abort      = 1'b0;
        shadow_wr  = idx_we | gain_we;
        safe_d     = safe_we ? safe_val : safe_q;

        unique case (state_q)
            // Commit is judged against the SAFE value held before any same-cycle update.
            StIdle: begin
                if (commit_req) begin
                    if (safe_q) begin
                        state_d = StPending;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            // A SAFE drop takes priority over a coincident frame boundary.
            StPending: begin
                if (!safe_d) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (frame_sync) begin
                    start_copy = 1'b1;
                    cnt_d      = '0;
                    state_d    = StCopy;
                end
            end
            StCopy: begin
                if (commit_req) begin
                    rearm_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ENTRY) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rearm_q) begin
                    rearm_d = 1'b0;
                    state_d = StPending;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        dirty_d = shadow_wr ? 1'b1 : (start_copy ? 1'b0 : dirty_q);
    end

    // The read runs one entry ahead of the registered beat: cnt_q is the beat on the port.
    always_comb begin
        rd_addr     = start_copy ? '0 : cnt_q + 1'b1;
        act_we_d    = start_copy | ((state_q == StCopy) && (cnt_q != LAST_ENTRY));
        act_ch_d    = 1'b0;
        act_tone_d  = '0;
        act_index_d = '0;
        act_gain_d  = '0;
        if (act_we_d) begin
            act_ch_d    = rd_addr[ADDR_W-1];
            act_tone_d  = rd_addr[ADDR_W-2:0];
            act_index_d = rd_index;
            act_gain_d  = rd_gain;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_q == StCopy) && (cnt_q == LAST_ENTRY);
        rej_d  = reject | abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_we_q    <= 1'b0;
            act_ch_q    <= 1'b0;
            act_tone_q  <= '0;
            act_index_q <= '0;
            act_gain_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            act_we_q    <= act_we_d;
            act_ch_q    <= act_ch_d;
            act_tone_q  <= act_tone_d;
            act_index_q <= act_index_d;
            act_gain_q  <= act_gain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rej_q       <= rej_d;
        end
    end

    assign act_we      = act_we_q;
    assign act_ch      = act_ch_q;
    assign act_tone    = act_tone_q;
    assign act_index   = act_index_q;
    assign act_gain    = act_gain_q;
    assign busy        = busy_q;
    assign dirty       = dirty_q;
    assign safe_state  = safe_q;
    assign commit_done = done_q;
    assign commit_rej  = rej_q;

endmodule

// File: doc/tone_cfg_commit_ctrl.md
# tone_cfg_commit_ctrl

Double-buffered tone-configuration controller between the AXIS command decoder and the DDS active tone table. Decoded index/gain writes land in a 16-entry shadow bank. A commit request, gated by the SAFE flag, is deferred to the next DDS frame boundary. The shadow bank is then copied into the active table over a sequenced 16-beat write burst, so the DDS never sees a half-updated frame.

## Interface
- IDX_W, 10, tone index width
- GAIN_W, 18, gain width (Q1.17)
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- idx_we  in  1  shadow index write strobe (decoder pulse)
- gain_we  in  1  shadow gain write strobe
- wr_ch  in  1  target channel (0=A, 1=B)
- wr_tone  in  3  target tone 0..7
- wr_index  in  IDX_W  index payload
- wr_gain  in  GAIN_W  gain payload
- commit_req  in  1  commit pulse
- safe_we  in  1  SAFE update strobe
- safe_val  in  1  SAFE value (1=allow commit)
- frame_sync  in  1  one-cycle DDS frame-boundary strobe
- act_we  out  1  active-table write strobe
- act_ch  out  1  active-table channel
- act_tone  out  3  active-table tone
- act_index  out  IDX_W  active-table index
- act_gain  out  GAIN_W  active-table gain
- busy  out  1  state != IDLE
- dirty  out  1  shadow modified since last copy started
- safe_state  out  1  current SAFE flag
- commit_done  out  1  one-cycle pulse, copy finished
- commit_rej  out  1  one-cycle pulse, commit refused or aborted

## Operation
- Shadow bank: 16 entries {index, gain}, addressed by {ch, tone}. idx_we writes the index only; gain_we writes the gain only. Both strobes in the same cycle write both fields. Any write sets dirty. Writes are accepted in every state.
- SAFE flag: updated by safe_we.
- States: IDLE, PENDING, COPY, DONE.
- IDLE: commit_req with safe_state=1 -> PENDING. commit_req with safe_state=0 -> commit_rej, stay IDLE. frame_sync is ignored.
- PENDING: frame_sync -> COPY; copy counter=0; dirty cleared. safe_state falling to 0 -> commit_rej, then IDLE. commit_req is ignored (already pending).
- COPY: one entry per cycle. Entry k = {ch=k[3], tone=k[2:0]}, order A0..A7, B0..B7. Entry data is the shadow contents at the cycle it is read. Counter 15 -> DONE.
  - SAFE changes do not abort a copy.
  - commit_req during COPY sets rearm.
- DONE: commit_done pulse. Go to PENDING if rearm=1 (then rearm cleared), else IDLE.
- Simultaneous events:
  - Shadow write to entry k in the same cycle entry k is read: the old value is copied, the new value is kept, and dirty=1.
  - Write in the PENDING->COPY transition cycle: dirty ends at 1.
  - safe_we=0 together with commit_req in IDLE: the commit is evaluated against the pre-update SAFE value.
  - frame_sync together with a SAFE drop in PENDING: the abort wins.
- Reset:
  - Outputs on reset: act_* =0, busy=0, dirty=0, safe_state=0, commit_done=0, commit_rej=0.
  - Internal state on reset: shadow=0, rearm=0, state=IDLE.
  - Reset mid-COPY leaves the active table partially written; no commit_done is issued.

## Timing
- All outputs registered.
- Shadow write is visible to the copy path one cycle after the strobe.
- commit_req sampled at edge E -> busy=1 from E+1. commit_rej asserted in cycle E+1 for one cycle.
- frame_sync sampled in PENDING at edge E -> act_we=1 for cycles E+1..E+16 with entries 0..15 -> commit_done in cycle E+17 -> busy=0 in cycle E+18 (unless rearmed).
- Worst-case commit latency: one frame period + 17 cycles.
- No backpressure on the active-table port.

## Structure
- Shared package tone_cfg_pkg:
  - IDX_W and GAIN_W defaults.
  - N_ENTRY=16.
  - State encoding IDLE/PENDING/COPY/DONE.
  - Entry-address helper {ch, tone}.
- Sub-module tone_shadow_bank: 16-entry register file with separate index/gain write enables, one synchronous write port and one combinational read port.
- FSM, counter, rearm and SAFE logic live in the top level.

## Test plan
- SAFE=1; write A3 index=0x155, gain=0x10000; commit; frame_sync 5 cycles later -> 16 act_we beats; beat 3 carries ch=0 tone=3 0x155/0x10000; commit_done 17 cycles after frame_sync.
- SAFE=0 (reset default); commit -> commit_rej one cycle later; busy stays 0; no act_we.
- Commit pending; safe_we with val=0 before frame_sync -> commit_rej; IDLE; a later frame_sync produces no act_we.
- commit_req during COPY beat 8 -> commit_done, then PENDING; next frame_sync triggers a second 16-beat burst.
- Gain write to B0 in the same cycle beat 8 (B0) is copied -> old gain copied; dirty=1 after done; next commit copies the new gain.
- Assert rst at beat 5 of COPY -> all outputs 0 the next cycle; no commit_done; shadow reads 0 on the next commit.
